// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects and FSM states.
package hazard_pkg;

   localparam int unsigned FWD_W = 2;

   typedef enum logic [FWD_W-1:0] {
      FWD_ID  = 2'b00,
      FWD_MEM = 2'b01,
      FWD_WB  = 2'b10
   } fwd_sel_e;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } hz_state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle: ID-stage instruction fields, EX/MEM events, and the
// stall/flush/forwarding controls returned to the datapath.
interface pipeline_hazard_ctrl_if #(
   parameter int unsigned REG_ADDR_W = 5
);
   import hazard_pkg::*;

   logic                  id_valid;
   logic [REG_ADDR_W-1:0] id_rs1;
   logic [REG_ADDR_W-1:0] id_rs2;
   logic                  id_uses_rs1;
   logic                  id_uses_rs2;
   logic [REG_ADDR_W-1:0] id_rd;
   logic                  id_wb_en;
   logic                  id_is_load;
   logic                  ex_branch_taken;
   logic                  mem_req;
   logic                  mem_ready;

   logic                  pc_stall;
   logic                  if_id_stall;
   logic                  id_ex_bubble;
   logic                  if_id_flush;
   logic                  pipe_freeze;
   fwd_sel_e              fwd_sel_rs1;
   fwd_sel_e              fwd_sel_rs2;
   fwd_sel_e              fwd_sel_store;
   logic [REG_ADDR_W-1:0] mem_rd;
   logic [REG_ADDR_W-1:0] wb_rd;

   // Datapath side
   modport master (
      output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd, id_wb_en, id_is_load,
             ex_branch_taken, mem_req, mem_ready,
      input  pc_stall, if_id_stall, id_ex_bubble, if_id_flush, pipe_freeze,
             fwd_sel_rs1, fwd_sel_rs2, fwd_sel_store, mem_rd, wb_rd
   );

   // Controller side
   modport slave (
      input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd, id_wb_en, id_is_load,
             ex_branch_taken, mem_req, mem_ready,
      output pc_stall, if_id_stall, id_ex_bubble, if_id_flush, pipe_freeze,
             fwd_sel_rs1, fwd_sel_rs2, fwd_sel_store, mem_rd, wb_rd
   );

endinterface

// File: rtl/pipeline_hazard_ctrl_rd_scoreboard.sv
// Shadow copy of the destination registers (and load flags) travelling through EX/MEM/WB.
module rd_scoreboard #(
   parameter int unsigned REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  freeze,
   input  logic                  bubble,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  id_wb_en,
   input  logic                  id_is_load,
   output logic [REG_ADDR_W-1:0] ex_rd,
   output logic                  ex_load,
   output logic [REG_ADDR_W-1:0] mem_rd,
   output logic                  mem_load,
   output logic [REG_ADDR_W-1:0] wb_rd
);

   // Advance the shadow pipe unless frozen; a bubble/flush or non-writer enters EX as rd 0
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ex_rd    <= '0;
         ex_load  <= 1'b0;
         mem_rd   <= '0;
         mem_load <= 1'b0;
         wb_rd    <= '0;
      end else if (!freeze) begin
         ex_rd    <= (!bubble && id_valid && id_wb_en) ? id_rd : '0;
         ex_load  <= !bubble && id_valid && id_is_load;
         mem_rd   <= ex_rd;
         mem_load <= ex_load;
         wb_rd    <= mem_rd;
      end
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: load-use stalls, memory-wait freeze,
// branch flushes and registered EX forwarding selects.
// Optional build macro HAZARD_PERF_CNT_EN adds saturating stall/flush/wait counters.
module pipeline_hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int unsigned REG_ADDR_W = 5
`ifdef HAZARD_PERF_CNT_EN
   , parameter int unsigned PERF_CNT_W = 32
`endif
) (
   input  logic                  clk,
   input  logic                  rst_n,
   pipeline_hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
   , output logic [PERF_CNT_W-1:0] perf_stall_cnt
   , output logic [PERF_CNT_W-1:0] perf_flush_cnt
   , output logic [PERF_CNT_W-1:0] perf_wait_cnt
`endif
);

   hz_state_e             state_q, state_d;
   logic                  freeze_c, flush_c, load_use_c, stall_c, bubble_c, id_adv_c;
   logic [REG_ADDR_W-1:0] ex_rd, mem_rd, wb_rd;
   logic                  ex_load, mem_load;
   fwd_sel_e              sel_rs1_q, sel_rs2_q, sel_st_q;

   // Nearest in-flight producer wins: EX-stage writer is in MEM when the consumer is in EX
   function automatic fwd_sel_e pick_src(input logic used, input logic [REG_ADDR_W-1:0] rs,
                                         input logic [REG_ADDR_W-1:0] ex_rd_i,
                                         input logic [REG_ADDR_W-1:0] mem_rd_i);
      fwd_sel_e sel;
      sel = FWD_ID;
      if (used && rs != '0) begin
         if (rs == ex_rd_i)       sel = FWD_MEM;
         else if (rs == mem_rd_i) sel = FWD_WB;
      end
      return sel;
   endfunction

   rd_scoreboard #(.REG_ADDR_W(REG_ADDR_W)) u_sb (
      .clk        (clk),
      .rst_n      (rst_n),
      .freeze     (freeze_c),
      .bubble     (bubble_c),
      .id_valid   (hz.id_valid),
      .id_rd      (hz.id_rd),
      .id_wb_en   (hz.id_wb_en),
      .id_is_load (hz.id_is_load),
      .ex_rd      (ex_rd),
      .ex_load    (ex_load),
      .mem_rd     (mem_rd),
      .mem_load   (mem_load),
      .wb_rd      (wb_rd)
   );

   // FSM state register
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= RUN;
      else        state_q <= state_d;
   end

   // Next state and hazard decode; memory wait overrides flush, flush overrides load-use
   always_comb begin
      state_d    = state_q;
      freeze_c   = 1'b0;
      case (state_q)
         RUN: begin
            if (hz.mem_req && !hz.mem_ready) begin
               state_d  = MEM_WAIT;
               freeze_c = 1'b1;
            end
         end
         MEM_WAIT: begin
            if (hz.mem_ready) state_d  = RUN;
            else              freeze_c = 1'b1;
         end
         default: state_d = RUN;
      endcase
      load_use_c = hz.id_valid && ex_load && (ex_rd != '0) &&
                   ((hz.id_uses_rs1 && hz.id_rs1 == ex_rd) ||
                    (hz.id_uses_rs2 && hz.id_rs2 == ex_rd));
      flush_c    = !freeze_c && hz.ex_branch_taken;
      stall_c    = !freeze_c && !flush_c && load_use_c;
      bubble_c   = flush_c || stall_c;
      id_adv_c   = !freeze_c && !bubble_c;
   end

   // Forwarding selects follow the instruction into EX; cleared on bubble, held while frozen
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sel_rs1_q <= FWD_ID;
         sel_rs2_q <= FWD_ID;
         sel_st_q  <= FWD_ID;
      end else if (!freeze_c) begin
         if (id_adv_c && hz.id_valid) begin
            sel_rs1_q <= pick_src(hz.id_uses_rs1, hz.id_rs1, ex_rd, mem_rd);
            sel_rs2_q <= pick_src(hz.id_uses_rs2, hz.id_rs2, ex_rd, mem_rd);
            sel_st_q  <= pick_src(1'b1, hz.id_rs2, ex_rd, mem_rd);
         end else begin
            sel_rs1_q <= FWD_ID;
            sel_rs2_q <= FWD_ID;
            sel_st_q  <= FWD_ID;
         end
      end
   end

   // A single stall suffices: the stalled-on load must sit in MEM on the following cycle
   assert property (@(posedge clk) disable iff (!rst_n) stall_c |=> mem_load);

`ifdef HAZARD_PERF_CNT_EN
   // Saturating event counters
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_stall_cnt <= '0;
         perf_flush_cnt <= '0;
         perf_wait_cnt  <= '0;
      end else begin
         if (stall_c && perf_stall_cnt != '1)  perf_stall_cnt <= perf_stall_cnt + PERF_CNT_W'(1);
         if (flush_c && perf_flush_cnt != '1)  perf_flush_cnt <= perf_flush_cnt + PERF_CNT_W'(1);
         if (freeze_c && perf_wait_cnt != '1)  perf_wait_cnt  <= perf_wait_cnt + PERF_CNT_W'(1);
      end
   end
`endif

   assign hz.pc_stall      = freeze_c || stall_c;
   assign hz.if_id_stall   = freeze_c || stall_c;
   assign hz.id_ex_bubble  = bubble_c;
   assign hz.if_id_flush   = flush_c;
   assign hz.pipe_freeze   = freeze_c;
   assign hz.fwd_sel_rs1   = sel_rs1_q;
   assign hz.fwd_sel_rs2   = sel_rs2_q;
   assign hz.fwd_sel_store = sel_st_q;
   assign hz.mem_rd        = mem_rd;
   assign hz.wb_rd         = wb_rd;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares.
module tb_pipeline_hazard_ctrl;
   import hazard_pkg::*;

   localparam logic [4:0] C_NONE  = 5'b00000;  // {pc_stall,if_id_stall,bubble,flush,freeze}
   localparam logic [4:0] C_STALL = 5'b11100;
   localparam logic [4:0] C_FLUSH = 5'b00110;
   localparam logic [4:0] C_WAIT  = 5'b11001;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pipeline_hazard_ctrl_if #(.REG_ADDR_W(5)) hz ();

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] perf_stall_cnt, perf_flush_cnt, perf_wait_cnt;
`endif

   pipeline_hazard_ctrl #(.REG_ADDR_W(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .hz    (hz)
`ifdef HAZARD_PERF_CNT_EN
      , .perf_stall_cnt (perf_stall_cnt)
      , .perf_flush_cnt (perf_flush_cnt)
      , .perf_wait_cnt  (perf_wait_cnt)
`endif
   );

   typedef struct {
      string       name;
      logic [20:0] exp;
   } exp_t;

   exp_t        q[$];
   int          errors = 0;
   int          checks = 0;
   logic [20:0] obs;

   assign obs = {hz.pc_stall, hz.if_id_stall, hz.id_ex_bubble, hz.if_id_flush, hz.pipe_freeze,
                 hz.fwd_sel_rs1, hz.fwd_sel_rs2, hz.fwd_sel_store, hz.mem_rd, hz.wb_rd};

   // Monitor: compare every queued expectation against the outputs mid-cycle
   always @(negedge clk) begin
      exp_t e;
      if (q.size() != 0) begin
         e = q.pop_front();
         checks++;
         if (obs !== e.exp) begin
            errors++;
            $display("FAIL %s: got ctl=%b sel=%b/%b/%b mem_rd=%0d wb_rd=%0d, want ctl=%b sel=%b/%b/%b mem_rd=%0d wb_rd=%0d",
                     e.name, obs[20:16], obs[15:14], obs[13:12], obs[11:10], obs[9:5], obs[4:0],
                     e.exp[20:16], e.exp[15:14], e.exp[13:12], e.exp[11:10], e.exp[9:5], e.exp[4:0]);
         end
      end
   end

   // Drive one cycle of inputs and queue the outputs expected during that cycle
   task automatic step(input string name, input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic [4:0] rd, input logic wb,
                       input logic ld, input logic br, input logic mreq, input logic mrdy,
                       input logic [4:0] ctl, input logic [1:0] s1, input logic [1:0] s2,
                       input logic [1:0] st, input logic [4:0] mrd, input logic [4:0] wrd);
      exp_t e;
      hz.id_valid        = v;
      hz.id_rs1          = rs1;
      hz.id_rs2          = rs2;
      hz.id_uses_rs1     = u1;
      hz.id_uses_rs2     = u2;
      hz.id_rd           = rd;
      hz.id_wb_en        = wb;
      hz.id_is_load      = ld;
      hz.ex_branch_taken = br;
      hz.mem_req         = mreq;
      hz.mem_ready       = mrdy;
      e.name = name;
      e.exp  = {ctl, s1, s2, st, mrd, wrd};
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input string name, input logic [4:0] ctl, input logic [1:0] s1,
                       input logic [1:0] s2, input logic [1:0] st, input logic [4:0] mrd,
                       input logic [4:0] wrd);
      step(name, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0, ctl, s1, s2, st, mrd, wrd);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      hz.id_valid = 0; hz.id_rs1 = 0; hz.id_rs2 = 0; hz.id_uses_rs1 = 0; hz.id_uses_rs2 = 0;
      hz.id_rd = 0; hz.id_wb_en = 0; hz.id_is_load = 0; hz.ex_branch_taken = 0;
      hz.mem_req = 0; hz.mem_ready = 0;
      repeat (2) @(posedge clk);
      #1;
      idle("reset", C_NONE, 2'd0, 2'd0, 2'd0, 5'd0, 5'd0);
      rst_n = 1'b1;

      // ld x5 ; add x6,x5,x1 -> one stall, then WB forwarding on rs1
      step("A1_ld_x5",     1, 5'd2, 5'd0, 1, 0, 5'd5, 1, 1, 0, 0, 0, C_NONE,  2'd0, 2'd0, 2'd0, 5'd0, 5'd0);
      step("A2_load_use",  1, 5'd5, 5'd1, 1, 1, 5'd6, 1, 0, 0, 0, 0, C_STALL, 2'd0, 2'd0, 2'd0, 5'd0, 5'd0);
      step("A3_no_2nd",    1, 5'd5, 5'd1, 1, 1, 5'd6, 1, 0, 0, 0, 0, C_NONE,  2'd0, 2'd0, 2'd0, 5'd5, 5'd0);
      idle("A4_fwd_wb",                                                 C_NONE,  2'd2, 2'd0, 2'd0, 5'd0, 5'd5);

      // add x3 ; sub x4,x3,x3 -> MEM forwarding on both operands and store data
      step("B1_add_x3",    1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0, 0, 0, C_NONE,  2'd0, 2'd0, 2'd0, 5'd6, 5'd0);
      step("B2_sub",       1, 5'd3, 5'd3, 1, 1, 5'd4, 1, 0, 0, 0, 0, C_NONE,  2'd0, 2'd0, 2'd0, 5'd0, 5'd6);
      idle("B3_fwd_mem",                                                C_NONE,  2'd1, 2'd1, 2'd1, 5'd3, 5'd0);

      // ld x0 ; use x0 -> no stall, no forwarding
      step("C1_ld_x0",     1, 5'd1, 5'd0, 1, 0, 5'd0, 1, 1, 0, 0, 0, C_NONE,  2'd0, 2'd0, 2'd0, 5'd4, 5'd3);
      step("C2_use_x0",    1, 5'd0, 5'd0, 1, 1, 5'd7, 1, 0, 0, 0, 0, C_NONE,  2'd0, 2'd0, 2'd0, 5'd0, 5'd4);
      idle("C3_x0_sel",                                                 C_NONE,  2'd0, 2'd0, 2'd0, 5'd0, 5'd0);

      // memory wait of 3 cycles with a branch arriving mid-wait
      step("D1_add_x7",    1, 5'd7, 5'd7, 1, 1, 5'd10, 1, 0, 0, 0, 0, C_NONE, 2'd0, 2'd0, 2'd0, 5'd7, 5'd0);
      step("D2_add_x10",   1, 5'd10, 5'd1, 1, 1, 5'd11, 1, 0, 0, 0, 0, C_NONE, 2'd2, 2'd2, 2'd2, 5'd0, 5'd7);
      step("D3_wait1",     1, 5'd11, 5'd11, 1, 1, 5'd12, 1, 0, 0, 1, 0, C_WAIT, 2'd1, 2'd0, 2'd0, 5'd10, 5'd0);
      step("D4_wait2_br",  1, 5'd11, 5'd11, 1, 1, 5'd12, 1, 0, 1, 1, 0, C_WAIT, 2'd1, 2'd0, 2'd0, 5'd10, 5'd0);
      step("D5_wait3_br",  1, 5'd11, 5'd11, 1, 1, 5'd12, 1, 0, 1, 1, 0, C_WAIT, 2'd1, 2'd0, 2'd0, 5'd10, 5'd0);
      step("D6_ready_br",  1, 5'd11, 5'd11, 1, 1, 5'd12, 1, 0, 1, 1, 1, C_FLUSH, 2'd1, 2'd0, 2'd0, 5'd10, 5'd0);
      idle("D7_resumed",                                                C_NONE,  2'd0, 2'd0, 2'd0, 5'd11, 5'd10);
`ifdef HAZARD_PERF_CNT_EN
      checks++;
      if (perf_wait_cnt !== 32'd3 || perf_flush_cnt !== 32'd1 || perf_stall_cnt !== 32'd1) begin
         errors++;
         $display("FAIL perf_cnt: got stall=%0d flush=%0d wait=%0d, want 1 1 3",
                  perf_stall_cnt, perf_flush_cnt, perf_wait_cnt);
      end
`endif

      // branch taken together with a load-use -> flush only, producer slot becomes rd 0
      step("E1_ld_x13",    1, 5'd1, 5'd0, 1, 0, 5'd13, 1, 1, 0, 0, 0, C_NONE, 2'd0, 2'd0, 2'd0, 5'd0, 5'd11);
      step("E2_br_lduse",  1, 5'd13, 5'd13, 1, 1, 5'd14, 1, 0, 1, 0, 0, C_FLUSH, 2'd0, 2'd0, 2'd0, 5'd0, 5'd0);
      step("E3_after_fl",  1, 5'd13, 5'd13, 1, 1, 5'd14, 1, 0, 0, 0, 0, C_NONE, 2'd0, 2'd0, 2'd0, 5'd13, 5'd0);
      idle("E4_fwd_wb",                                                 C_NONE,  2'd2, 2'd2, 2'd2, 5'd0, 5'd13);

      // store: data select uses rs2 even when rs2 is not an ALU operand
      step("F1_store",     1, 5'd1, 5'd14, 1, 0, 5'd0, 0, 0, 0, 0, 0, C_NONE, 2'd0, 2'd0, 2'd0, 5'd14, 5'd0);
      idle("F2_st_sel",                                                 C_NONE,  2'd0, 2'd0, 2'd2, 5'd0, 5'd14);

      // reset while in MEM_WAIT
      step("G1_add_x15",   1, 5'd1, 5'd2, 1, 1, 5'd15, 1, 0, 0, 0, 0, C_NONE, 2'd0, 2'd0, 2'd0, 5'd0, 5'd0);
      step("G2_wait",      0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0, C_WAIT,  2'd0, 2'd0, 2'd0, 5'd0, 5'd0);
      step("G3_wait",      0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0, C_WAIT,  2'd0, 2'd0, 2'd0, 5'd0, 5'd0);
      rst_n = 1'b0;
      idle("G4_rst_in_wait",                                            C_WAIT,  2'd0, 2'd0, 2'd0, 5'd0, 5'd0);
      rst_n = 1'b1;
      step("G5_after_rst", 1, 5'd15, 5'd15, 1, 1, 5'd16, 1, 0, 0, 0, 0, C_NONE, 2'd0, 2'd0, 2'd0, 5'd0, 5'd0);
      idle("G6_ex_cleared",                                             C_NONE,  2'd0, 2'd0, 2'd0, 5'd0, 5'd0);

      @(negedge clk);
      #1;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expectations, want 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage RV64 pipeline (IF/ID/EX/MEM/WB). It keeps a shadow copy of the destination registers in flight and detects load-use and memory-wait hazards. It drives PC/IF-ID stalls, ID-EX bubbles and branch flushes, and generates registered operand-forwarding selects that steer the EX-stage forwarding mux.

Parameters:
REG_ADDR_W, 5, register index width
PERF_CNT_W, 32, width of performance counters (optional feature only)

Ports:
clk  in  1  pipeline clock
rst_n  in  1  synchronous active-low reset
id_valid  in  1  ID stage holds a valid instruction
id_rs1  in  5  ID source register 1
id_rs2  in  5  ID source register 2
id_uses_rs1  in  1  instruction reads rs1
id_uses_rs2  in  1  instruction reads rs2 (0 for immediate forms)
id_rd  in  5  ID destination register
id_wb_en  in  1  instruction writes rd
id_is_load  in  1  instruction is a load
ex_branch_taken  in  1  EX resolved a taken branch/jump
mem_req  in  1  MEM stage has an outstanding data access
mem_ready  in  1  data memory completes the access this cycle
pc_stall  out  1  hold PC
if_id_stall  out  1  hold IF/ID register
id_ex_bubble  out  1  load NOP into ID/EX
if_id_flush  out  1  squash IF/ID contents
pipe_freeze  out  1  hold ID/EX, EX/MEM, MEM/WB (memory wait)
fwd_sel_rs1  out  2  EX operand1 source: 00 ID value, 01 MEM-stage ALU result, 10 WB result
fwd_sel_rs2  out  2  same for operand2
fwd_sel_store  out  2  same for store data (rs2 of stores, ignores id_uses_rs2)
mem_rd  out  5  rd of instruction in MEM (0 if none)
wb_rd  out  5  rd of instruction in WB (0 if none)

Behaviour:
- Reset (rst_n=0 on a clk edge): state RUN; all shadow rd/load flags 0; all outputs 0.
- Shadow scoreboard: ex_rd/ex_load, mem_rd/mem_load, wb_rd. rd recorded as 0 when wb_en=0. Advance on each edge unless pipe_freeze. ex_* takes the ID values when ID advances, else 0 (bubble or flush).
- Load-use (combinational): id_valid && ex_load && ex_rd!=0 && ((id_uses_rs1 && id_rs1==ex_rd) || (id_uses_rs2 && id_rs2==ex_rd)) -> pc_stall=if_id_stall=id_ex_bubble=1 for exactly 1 cycle. The next cycle the producer is in MEM with mem_load=1 and forwarding uses WB one cycle later; a second stall is never needed.
- Forward selects: registered into EX when ID advances, from the ID rs fields. Compare against ex_rd first (selects 01), then mem_rd (selects 10), else 00. rd==0 never matches. Operand unused -> 00. Hold while frozen.
- Priority: MEM_WAIT > branch flush > load-use.
- FSM:
  - RUN: mem_req && !mem_ready -> MEM_WAIT, with pipe_freeze, pc_stall and if_id_stall asserted in that same cycle. Else if ex_branch_taken -> if_id_flush=1 and id_ex_bubble=1, stay in RUN.
  - MEM_WAIT: all holds asserted; flush and bubble suppressed; a taken branch in EX is held, not lost. mem_ready=1 -> RUN, with holds deasserted combinationally that cycle.
- Simultaneous branch and load-use: flush wins; no stall cycle is issued.
- rst_n low in MEM_WAIT: returns to RUN and clears all shadows.

Optional Feature:
HAZARD_PERF_CNT_EN: adds outputs perf_stall_cnt, perf_flush_cnt, perf_wait_cnt, each PERF_CNT_W wide.
- Counters increment on load-use stall cycles, flush cycles and MEM_WAIT cycles respectively.
- All counters reset to 0 and saturate at all-ones.
- Without the macro these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Package hazard_pkg: fwd_sel encodings (FWD_ID=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10) and FSM state encoding (RUN, MEM_WAIT).
- Sub-module rd_scoreboard: shadow rd/load pipeline with freeze and bubble inputs.
- Hazard detection, FSM and select registers stay in the top module.

Test Plan:
- ld x5 then add x6,x5,x1 back-to-back -> one cycle with pc_stall/if_id_stall/id_ex_bubble=1. The add then reaches EX with fwd_sel_rs1=10; fwd_sel_rs2=00.
- add x3 then sub x4,x3,x3 -> no stall; fwd_sel_rs1=fwd_sel_rs2=01 in the sub's EX cycle.
- addi x0 writer then use of x0 -> selects stay 00; no stall.
- mem_req=1, mem_ready low for 3 cycles -> pipe_freeze high 3 cycles; selects and mem_rd/wb_rd unchanged; RUN resumes on mem_ready.
- ex_branch_taken during a load-use -> if_id_flush=id_ex_bubble=1 for 1 cycle, pc_stall=0; ex_rd=0 next cycle.
- rst_n=0 during MEM_WAIT -> next cycle all outputs 0 and state RUN. With HAZARD_PERF_CNT_EN: perf_wait_cnt reads 3 after the wait scenario.
